data_frame_tx: RTL

Transmit end of the channel word-stream interface. On a start request it drives an active-low sync pulse, then pulls words from an upstream source and emits them as single-cycle strobes until the frame is complete. A frame carries words_num+1 words, indices 0..words_num, which is exactly what the channel word counter at the receive end accepts before it flags the channel complete. It sits between the channel data source and the serial/link side of the stick interface.

---
 rtl/data_frame_tx_pkg.sv | 17 +
 rtl/data_frame_tx_delay_cnt.sv | 28 ++
 rtl/data_frame_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/data_frame_tx_pkg.sv
// rtl/data_frame_tx_pkg.sv - shared types and widths for the frame transmitter
package data_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        WAIT = 3'd2,
        STB  = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int SYNC_CNT_W = 4;
    localparam int GAP_CNT_W  = 4;
    localparam int WCNT_W     = 9;

endpackage

// File: rtl/data_frame_tx_delay_cnt.sv
// rtl/data_frame_tx_delay_cnt.sv - loadable down-counter with zero flag for sync/gap timing
module frame_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; decrement saturates at zero so an idle counter stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_frame_tx.sv
// rtl/data_frame_tx.sv - frame transmitter: sync pulse then words_num+1 word strobes
module data_frame_tx
    import data_frame_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SYNC_LEN = 2,
    parameter int GAP_LEN  = 1
) (
    input  logic              clk20,
    input  logic              res,
    input  logic              start,
    input  logic [7:0]        words_num,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              sync_n,
    output logic              word_stb,
    output logic [DATA_W-1:0] word_data,
    output logic              busy,
    output logic              frame_done
);

    // Counter is loaded with length-1 so that the zero flag marks the final cycle of a phase
    localparam logic [SYNC_CNT_W-1:0] SYNC_LOAD = SYNC_CNT_W'(SYNC_LEN - 1);
    localparam logic [GAP_CNT_W-1:0]  GAP_LOAD  = GAP_CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam bit                    HAS_GAP   = (GAP_LEN > 0);

    state_t              state;
    logic [7:0]          wn_q;
    logic [WCNT_W-1:0]   wcnt;
    logic                last_word;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [SYNC_CNT_W-1:0] cnt_val;

    assign last_word = (wcnt == {{(WCNT_W-8){1'b0}}, wn_q});
    assign src_ready = (state == WAIT);

    // One delay counter serves both phases: reloaded on entry to SYNC and to GAP
    assign cnt_load = ((state == IDLE) && start) || ((state == STB) && !last_word && HAS_GAP);
    assign cnt_val  = (state == IDLE) ? SYNC_LOAD : GAP_LOAD;
    assign cnt_dec  = (state == SYNC) || (state == GAP);

    frame_delay_cnt #(
        .W(SYNC_CNT_W)
    ) u_delay (
        .clk      (clk20),
        .rst      (res),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Frame sequencer with registered outputs
    always_ff @(posedge clk20 or posedge res) begin
        if (res) begin
            state      <= IDLE;
            wn_q       <= '0;
            wcnt       <= '0;
            sync_n     <= 1'b1;
            word_stb   <= 1'b0;
            word_data  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wn_q   <= words_num;
                        wcnt   <= '0;
                        sync_n <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SYNC;
                    end
                end
                SYNC: begin
                    if (cnt_zero) begin
                        sync_n <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (src_valid) begin
                        word_data <= src_data;
                        word_stb  <= 1'b1;
                        state     <= STB;
                    end
                end
                STB: begin
                    word_stb <= 1'b0;
                    wcnt     <= wcnt + 1'b1;
                    if (last_word) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else if (HAS_GAP) begin
                        state <= GAP;
                    end else begin
                        state <= WAIT;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
